pattern_det_ctrl: RTL and testbench
===================================

// Module: pattern_det_ctrl
// PURPOSE
//   Programmable serial pattern-detector controller. Holds a 1..MAXLEN-bit pattern
//   and a mode (overlapping / non-overlapping), scans a qualified serial bit stream,
//   and pulses on each match. Counts matches and stops automatically at a threshold.
//   Sits between the config/control logic and the serial bit source; supersedes
//   fixed-pattern detectors.
// PARAMETERS
//   MAXLEN  8  maximum pattern length, in bits (>=2)
//   CNT_W   8  width of the match counter and threshold
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous, active-low reset
//   cfg_we       in   1       configuration write strobe
//   cfg_pattern  in   MAXLEN  pattern; bit [cfg_len-1] is received first
//   cfg_len      in   4       pattern length, legal range 1..MAXLEN
//   cfg_overlap  in   1       1 = overlapping matches, 0 = non-overlapping
//   cfg_thresh   in   CNT_W   stop after this many matches; 0 = run until stop
//   start        in   1       start-scan request (single-cycle pulse)
//   stop         in   1       abort-scan request (single-cycle pulse)
//   bit_valid    in   1       bit_in is valid this cycle
//   bit_in       in   1       serial data bit
//   busy         out  1       high while in state RUN
//   match        out  1       1-cycle pulse per detected match
//   match_cnt    out  CNT_W   matches counted since last start; saturating
//   done         out  1       threshold reached; held high until next start or cfg_we
//   cfg_err      out  1       1-cycle pulse on a rejected config write
// BEHAVIOUR
//   Reset (rst=0, async): all outputs 0; state IDLE; sr=0; fill=0.
//     Config resets to pattern=...101, len=3, overlap=1, thresh=0.
//   States: IDLE, RUN, DONE. All outputs are registered.
//   Config write:
//     - Accepted only in IDLE or DONE, and only if 1<=cfg_len<=MAXLEN.
//     - Accepted write latches all four cfg_* fields; in DONE it also clears done
//       and returns to IDLE.
//     - Rejected write (state RUN, or illegal cfg_len): config unchanged;
//       cfg_err=1 on the next cycle for exactly 1 cycle.
//   start in IDLE/DONE -> RUN next cycle:
//     - match_cnt=0, sr=0, fill=0, done=0, busy=1.
//     - Ignored in RUN. If cfg_we and start coincide, the write wins; start is dropped.
//   RUN, each cycle with bit_valid=1 (and no stop):
//     - sr_n = {sr[MAXLEN-2:0], bit_in}; fill_n = min(fill+1, MAXLEN).
//     - hit = (fill_n >= len) && (sr_n[len-1:0] == pattern[len-1:0]).
//   On hit (registered next cycle):
//     - match=1 for 1 cycle; match_cnt+1, saturating at 2^CNT_W-1.
//     - overlap=1: fill kept. overlap=0: fill=0, so len fresh bits are needed
//       before the next match.
//   Threshold: if thresh!=0 and the post-increment count == thresh:
//     - Enter DONE in the same edge as the match pulse: done=1, busy=0.
//     - Bits in DONE are ignored; match_cnt holds.
//   Latency: match/match_cnt/done change on the edge after the completing bit_valid cycle.
//   bit_valid=0: no state change. bit_valid is ignored outside RUN.
//   stop in RUN -> IDLE next cycle:
//     - busy=0; match_cnt held; done unchanged (0).
//     - Any bit_valid in the same cycle is discarded (no match, no count).
//     - stop in IDLE/DONE: no effect. stop and start together in RUN: stop wins.
//   rst asserted mid-RUN: immediate return to the reset state; no partial match survives.
// TESTING
//   T1 reset defaults, start, bits 1,0,1,0,1 -> match pulses after bits 3 and 5;
//      match_cnt=2; busy=1.
//   T2 overlap=0, len=3, pat=101; stream 1,0,1,0,1 -> one match, cnt=1;
//      continue 1,0,1 -> cnt=2.
//   T3 len=4, pat=1101, thresh=3, overlap=1; stream 1101101101 ->
//      3rd match sets done=1 and busy=0 in the same cycle; later bits leave cnt=3.
//   T4 cfg_we in RUN -> cfg_err 1-cycle pulse, pattern unchanged.
//      cfg_len=0 or 9 in IDLE -> cfg_err; old config still detects 101.
//   T5 stop with bit_valid completing a match -> no match pulse, IDLE, cnt held;
//      stop+start together -> IDLE. rst low mid-RUN -> all outputs 0 before the next edge.
//   T6 CNT_W=2, thresh=0, len=1, pat=1, five 1-bits -> 5 match pulses, match_cnt saturates at 3.

Source files
------------

// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern detector: scans qualified bits for a 1..MAXLEN-bit
// pattern (overlapping or not), pulses per match, counts, and stops at a threshold.
module pattern_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              start,
    input  logic              stop,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              done,
    output logic              cfg_err
);

    localparam int                FILL_W   = $clog2(MAXLEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAXLEN);
    localparam logic [3:0]        LEN_MAX  = 4'(MAXLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [MAXLEN-1:0]  sr_q;
    logic [FILL_W-1:0]  fill_q;
    logic [MAXLEN-1:0]  pat_q;
    logic [3:0]         len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   thr_q;
    logic               busy_q;
    logic               match_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic               err_q;

    logic [MAXLEN-1:0]  sr_d;
    logic [FILL_W-1:0]  fill_d;
    logic [MAXLEN-1:0]  mask_s;
    logic               hit_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               cfg_ok_s;

    // Candidate shift/fill update and match decision for the current bit
    always_comb begin
        sr_d   = {sr_q[MAXLEN-2:0], bit_in};
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
        mask_s = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask_s[i] = (i < int'(len_q));
        end
        hit_s     = (int'(fill_d) >= int'(len_q)) && (((sr_d ^ pat_q) & mask_s) == '0);
        cnt_inc_s = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        cfg_ok_s  = (cfg_len != 4'd0) && (cfg_len <= LEN_MAX);
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            fill_q  <= '0;
            pat_q   <= MAXLEN'(3'b101);
            len_q   <= 4'd3;
            ovl_q   <= 1'b1;
            thr_q   <= '0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            match_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A config write always takes priority over a coincident start
                    if (cfg_we) begin
                        if (cfg_ok_s) begin
                            pat_q   <= cfg_pattern;
                            len_q   <= cfg_len;
                            ovl_q   <= cfg_overlap;
                            thr_q   <= cfg_thresh;
                            done_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (start) begin
                        state_q <= S_RUN;
                        sr_q    <= '0;
                        fill_q  <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_RUN: begin
                    err_q <= cfg_we;
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (bit_valid) begin
                        sr_q   <= sr_d;
                        // Non-overlapping mode needs len fresh bits after each match
                        fill_q <= (hit_s && !ovl_q) ? '0 : fill_d;
                        if (hit_s) begin
                            match_q <= 1'b1;
                            cnt_q   <= cnt_inc_s;
                            if ((thr_q != '0) && (cnt_inc_s == thr_q)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Bench for pattern_det_ctrl: a queue-based behavioural model checked every cycle
// against two instances (CNT_W=8 and CNT_W=2) sharing one stimulus stream.
module tb_pattern_det_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_thresh;
    logic       start;
    logic       stop;
    logic       bit_valid;
    logic       bit_in;

    logic       busy1, match1, done1, err1;
    logic [7:0] cnt1;
    logic       busy2, match2, done2, err2;
    logic [1:0] cnt2;

    int n_cmp  = 0;
    int n_fail = 0;

    pattern_det_ctrl #(.MAXLEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
        .busy(busy1), .match(match1), .match_cnt(cnt1), .done(done1), .cfg_err(err1)
    );

    pattern_det_ctrl #(.MAXLEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh[1:0]),
        .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
        .busy(busy2), .match(match2), .match_cnt(cnt2), .done(done2), .cfg_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the bits seen since the last start (or last
    // non-overlapping match) are kept in a queue.
    bit       m_run, m_done, m_match, m_err;
    int       m_cnt;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_thr;
    bit       hist[$];

    always @(posedge clk) begin
        bit hit;
        int e1;
        m_match = 1'b0;
        m_err   = 1'b0;
        if (!rst) begin
            m_run = 1'b0; m_done = 1'b0; m_cnt = 0;
            m_pat = 8'b101; m_len = 3; m_ovl = 1'b1; m_thr = 0;
            hist.delete();
        end else if (!m_run) begin
            if (cfg_we) begin
                if (cfg_len >= 4'd1 && cfg_len <= 4'd8) begin
                    m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap;
                    m_thr = cfg_thresh; m_done = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (start) begin
                m_run = 1'b1; m_cnt = 0; m_done = 1'b0;
                hist.delete();
            end
        end else begin
            if (cfg_we) m_err = 1'b1;
            if (stop) begin
                m_run = 1'b0;
            end else if (bit_valid) begin
                hist.push_back(bit_in);
                hit = (hist.size() >= m_len);
                for (int k = 0; k < m_len && hit; k++) begin
                    if (hist[hist.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit) begin
                    m_match = 1'b1;
                    m_cnt++;
                    if (!m_ovl) hist.delete();
                    e1 = (m_cnt > 255) ? 255 : m_cnt;
                    if (m_thr != 0 && e1 == m_thr) begin
                        m_run = 1'b0; m_done = 1'b1;
                    end
                end
            end
        end
        #1;
        chk("busy",   busy1,  m_run);
        chk("match",  match1, m_match);
        chk("cnt",    cnt1,   (m_cnt > 255) ? 255 : m_cnt);
        chk("done",   done1,  m_done);
        chk("err",    err1,   m_err);
        chk("busy2",  busy2,  m_run);
        chk("match2", match2, m_match);
        chk("cnt2",   cnt2,   (m_cnt > 3) ? 3 : m_cnt);
        chk("done2",  done2,  m_done);
        chk("err2",   err2,   m_err);
    end

    task automatic drive(input logic we, input logic st, input logic sp,
                         input logic bv, input logic b);
        cfg_we = we; start = st; stop = sp; bit_valid = bv; bit_in = b;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b0, 1'b1, v[i]);
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] l,
                           input logic o, input logic [7:0] t);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_thresh = t;
    endtask

    initial begin
        rst = 1'b0;
        set_cfg(8'h00, 4'd0, 1'b0, 8'd0);
        cfg_we = 1'b0; start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle();
        chk("rst_busy", busy1, 0);
        chk("rst_cnt",  cnt1,  0);
        chk("rst_done", done1, 0);

        // T1: defaults (101, overlapping)
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b10101, 5);
        chk("t1_match", match1, 1);
        chk("t1_cnt",   cnt1,   2);
        chk("t1_busy",  busy1,  1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T2: non-overlapping 101
        set_cfg(8'b101, 4'd3, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b10101, 5);
        chk("t2_cnt_a", cnt1, 1);
        send_bits(16'b101, 3);
        chk("t2_cnt_b", cnt1, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T3: 1101 overlapping, threshold 3
        set_cfg(8'b1101, 4'd4, 1'b1, 8'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b1101101101, 10);
        chk("t3_done",  done1,  1);
        chk("t3_busy",  busy1,  0);
        chk("t3_match", match1, 1);
        send_bits(16'b1101, 4);
        chk("t3_cnt",   cnt1,   3);

        // T4: write from DONE, rejected writes in RUN and with bad lengths
        set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_done_clr", done1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_cfg(8'b111, 4'd3, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_err_run", err1, 1);
        idle();
        chk("t4_err_pulse", err1, 0);
        send_bits(16'b101, 3);
        chk("t4_cnt_run", cnt1, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_cfg(8'b111, 4'd0, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_err_len0", err1, 1);
        set_cfg(8'b111, 4'd9, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_err_len9", err1, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b11101, 5);
        chk("t4_old_cfg", cnt1, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T5: stop discards a completing bit; stop+start; async reset
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b1010, 4);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_stop_match", match1, 0);
        chk("t5_stop_busy",  busy1,  0);
        chk("t5_stop_cnt",   cnt1,   1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_ss_busy", busy1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b1010, 4);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_busy",  busy1,  0);
        chk("t5_rst_cnt",   cnt1,   0);
        chk("t5_rst_match", match1, 0);
        chk("t5_rst_done",  done1,  0);
        chk("t5_rst_err",   err1,   0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b1, 1);
        chk("t5_no_partial", cnt1, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T6: single-bit pattern, counter saturation on the 2-bit instance
        set_cfg(8'b1, 4'd1, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b11111, 5);
        idle();
        chk("t6_cnt8", cnt1, 5);
        chk("t6_cnt2", cnt2, 3);
        repeat (2) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
